// File: rtl/retospect_config_loader.sv
// Purpose: serial configuration-chain loader with an optional CRC-8 readback verify pass.
// Latency: the first chain bit appears the cycle after a byte is accepted; one bit per cycle after that.
// Backpressure: byte_ready drops while the buffer holds two or more bits or the chain is already fully requested.
// Ports: clk/reset (sync, active-high); start/verify_en/abort control; byte_in/byte_valid/byte_ready input stream;
//        config_en/bs_out/bs_ret chain interface; reset_nn/busy/done/error/crc_out status.
module retospect_config_loader #(
  parameter int CHAIN_LEN = 1568,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       verify_en,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       config_en,
  output logic       bs_out,
  input  logic       bs_ret,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] crc_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_ARM    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W:0]   LP_CHAIN = (CNT_W+1)'(CHAIN_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_verify;
  logic             r_error;
  logic [7:0]       r_buf;
  logic [3:0]       r_fill;
  logic [CNT_W-1:0] r_bitcnt;
  logic [7:0]       r_crc;
  logic [7:0]       r_crc_rb;
  logic [7:0]       r_crc_out;

  logic             w_shift;
  logic             w_last_load;
  logic             w_last_vfy;
  logic [CNT_W:0]   w_req;
  logic             w_byte_ready;
  logic             w_accept;
  logic [7:0]       w_crc_ld_nxt;
  logic [7:0]       w_crc_rb_nxt;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Bits requested = bits already shifted + bits still waiting in the buffer.
  assign w_req        = {1'b0, r_bitcnt} + (CNT_W+1)'(r_fill);
  assign w_shift      = (r_state == S_LOAD) && (r_fill != 4'd0);
  assign w_last_load  = w_shift && (r_bitcnt == LP_LAST);
  assign w_last_vfy   = (r_state == S_VERIFY) && (r_bitcnt == LP_LAST);
  // Accepting on the last buffered bit keeps the shift gap-free.
  assign w_byte_ready = (r_state == S_LOAD)
                        && ((r_fill == 4'd0) || ((r_fill == 4'd1) && w_shift))
                        && (w_req < LP_CHAIN);
  assign w_accept     = byte_valid && w_byte_ready;
  assign w_crc_ld_nxt = crc8_step(r_crc, r_buf[0]);
  assign w_crc_rb_nxt = crc8_step(r_crc_rb, bs_ret);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_last_load) w_state_nxt = r_verify ? S_VERIFY : S_ARM;
      end
      S_VERIFY: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_last_vfy) w_state_nxt = (w_crc_rb_nxt == r_crc_out) ? S_ARM : S_FINISH;
      end
      S_ARM:    w_state_nxt = abort ? S_IDLE : S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_verify  <= 1'b0;
      r_error   <= 1'b0;
      r_buf     <= 8'h00;
      r_fill    <= 4'd0;
      r_bitcnt  <= '0;
      r_crc     <= 8'h00;
      r_crc_rb  <= 8'h00;
      r_crc_out <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_verify <= verify_en;
            r_error  <= 1'b0;
            r_buf    <= 8'h00;
            r_fill   <= 4'd0;
            r_bitcnt <= '0;
            r_crc    <= 8'h00;
            r_crc_rb <= 8'h00;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_error <= 1'b1;
            r_fill  <= 4'd0;
          end else begin
            if (w_shift) begin
              r_crc    <= w_crc_ld_nxt;
              r_bitcnt <= r_bitcnt + CNT_W'(1);
              r_buf    <= {1'b0, r_buf[7:1]};
              r_fill   <= r_fill - 4'd1;
            end
            if (w_accept) begin
              r_buf  <= byte_in;
              r_fill <= 4'd8;
            end
            // Chain full: drop leftover buffered bits and rearm the counter for VERIFY.
            if (w_last_load) begin
              r_crc_out <= w_crc_ld_nxt;
              r_bitcnt  <= '0;
              r_fill    <= 4'd0;
              r_crc_rb  <= 8'h00;
            end
          end
        end
        S_VERIFY: begin
          if (abort) begin
            r_error <= 1'b1;
          end else begin
            r_crc_rb <= w_crc_rb_nxt;
            r_bitcnt <= r_bitcnt + CNT_W'(1);
            if (w_last_vfy && (w_crc_rb_nxt != r_crc_out)) r_error <= 1'b1;
          end
        end
        S_ARM: begin
          if (abort) r_error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign byte_ready = w_byte_ready;
  assign config_en  = w_shift || (r_state == S_VERIFY);
  assign bs_out     = w_shift ? r_buf[0] : ((r_state == S_VERIFY) ? bs_ret : 1'b0);
  // An abort landing in ARM suppresses the pulse in that same cycle.
  assign reset_nn   = (r_state == S_ARM) && !abort;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);
  assign error      = r_error;
  assign crc_out    = r_crc_out;

endmodule

// File: tb/tb_retospect_config_loader.sv
// Purpose: bench for retospect_config_loader on a 12-bit chain model with randomized loads.
// Latency: n/a.
// Backpressure: bytes are offered until byte_ready, with bounded waits.
module tb_retospect_config_loader;

  localparam int CL = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       verify_en;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       config_en;
  logic       bs_out;
  logic       bs_ret;
  logic       reset_nn;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] crc_out;

  retospect_config_loader #(.CHAIN_LEN(CL), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .config_en(config_en), .bs_out(bs_out), .bs_ret(bs_ret), .reset_nn(reset_nn),
    .busy(busy), .done(done), .error(error), .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Chain model: 12-bit shift register; the first bit in exits first.
  logic [CL-1:0] chain = '0;
  int n_cfg = 0;
  int cfg_base = 0;
  int flip_idx = -1;
  logic flip_now;
  assign flip_now = config_en && (flip_idx >= 0) && ((n_cfg - cfg_base) == CL + flip_idx);
  assign bs_ret = chain[CL-1] ^ flip_now;

  always @(posedge clk) begin
    if (config_en) begin
      chain <= {chain[CL-2:0], bs_out};
      n_cfg <= n_cfg + 1;
    end
  end

  // Monitor: monotonic history; each run works from snapshots.
  logic q_bits[$];
  int n_rnn = 0, n_done = 0, n_acc = 0, n_viol = 0;
  always @(negedge clk) begin
    if (config_en) q_bits.push_back(bs_out);
    if (reset_nn) n_rnn++;
    if (done) n_done++;
    if (byte_valid && byte_ready) n_acc++;
    if ((config_en && reset_nn) || (!config_en && bs_out)) n_viol++;
  end

  function automatic logic [7:0] crc_of(input logic [CL-1:0] bits);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < CL; i++) begin
      logic fb = c[7] ^ bits[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic feed(input logic [7:0] b, input string tag);
    logic acc = 1'b0;
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    byte_valid = 1'b0;
    if (!acc) chk({tag, "_feed_timeout"}, 32'(acc), 32'd1);
  endtask

  task automatic do_start(input logic vfy);
    @(posedge clk); #1;
    start = 1'b1;
    verify_en = vfy;
    @(posedge clk); #1;
    start = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input logic vfy,
                          input int gap, input int fidx, input string tag);
    logic [15:0]   w = {b1, b0};
    logic [CL-1:0] exp_bits, exp_rb, got_ld, got_rb, exp_chain;
    int qb, rnn0, done0, acc0, viol0, n;
    logic exp_err;
    exp_bits = w[CL-1:0];
    exp_rb   = exp_bits;
    if (vfy && fidx >= 0) exp_rb[fidx] = ~exp_rb[fidx];
    exp_chain = '0;
    for (int i = 0; i < CL; i++) exp_chain = {exp_chain[CL-2:0], (vfy ? exp_rb[i] : exp_bits[i])};
    exp_err = vfy && (fidx >= 0);
    @(negedge clk);
    qb = q_bits.size(); rnn0 = n_rnn; done0 = n_done; acc0 = n_acc; viol0 = n_viol;
    cfg_base = n_cfg;
    flip_idx = vfy ? fidx : -1;
    do_start(vfy);
    feed(b0, tag);
    if (gap > 0) begin
      repeat (7 + gap) @(posedge clk);
      #1;
    end
    start = 1'b1;
    feed(b1, tag);
    byte_valid = 1'b1;
    byte_in = 8'($urandom);
    n = 0;
    while (n_done == done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, 32'(n_done != done0), 32'd1);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    got_ld = '0; got_rb = '0;
    for (int i = 0; i < CL; i++) begin
      if (qb + i < q_bits.size())      got_ld[i] = q_bits[qb + i];
      if (qb + CL + i < q_bits.size()) got_rb[i] = q_bits[qb + CL + i];
    end
    chk({tag, "_load_bits"}, 32'(got_ld), 32'(exp_bits));
    chk({tag, "_cfg_cycles"}, 32'(q_bits.size() - qb), vfy ? 32'(2 * CL) : 32'(CL));
    if (vfy) chk({tag, "_readback"}, 32'(got_rb), 32'(exp_rb));
    chk({tag, "_chain"}, 32'(chain), 32'(exp_chain));
    chk({tag, "_crc_out"}, 32'(crc_out), 32'(crc_of(exp_bits)));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_reset_nn"}, 32'(n_rnn - rnn0), exp_err ? 32'd0 : 32'd1);
    chk({tag, "_done"}, 32'(n_done - done0), 32'd1);
    chk({tag, "_accepts"}, 32'(n_acc - acc0), 32'd2);
    chk({tag, "_viol"}, 32'(n_viol - viol0), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    flip_idx = -1;
  endtask

  initial begin
    int rnn0, done0, n;
    reset = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({byte_ready, config_en, bs_out, reset_nn, done, error}), 32'd0);
    chk("rst_crc", 32'(crc_out), 32'd0);
    reset = 1'b0;

    run_load(8'hA5, 8'h0F, 1'b0, 0, -1, "basic");
    run_load(8'hA5, 8'h0F, 1'b1, 0, -1, "verify");
    run_load(8'hA5, 8'h0F, 1'b1, 0, 5, "badret");
    run_load(8'hA5, 8'h0F, 1'b0, 5, -1, "gaps");

    // Abort after 6 load bits.
    @(negedge clk);
    rnn0 = n_rnn; done0 = n_done; cfg_base = n_cfg;
    do_start(1'b0);
    feed(8'hA5, "abort");
    n = 0;
    while ((n_cfg - cfg_base) < 6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_wait", 32'(n_cfg - cfg_base), 32'd6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cfg", 32'(config_en), 32'd0);
    chk("abort_err", 32'(error), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_done", 32'(n_done - done0), 32'd0);
    chk("abort_rnn", 32'(n_rnn - rnn0), 32'd0);
    run_load(8'h3C, 8'hC3, 1'b0, 0, -1, "after_abort");

    // Reset mid-VERIFY, with a concurrent start that must lose to reset.
    @(negedge clk);
    cfg_base = n_cfg;
    do_start(1'b1);
    feed(8'h5A, "rstv");
    feed(8'h81, "rstv");
    n = 0;
    while ((n_cfg - cfg_base) < CL + 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("rstv_busy", 32'(busy), 32'd0);
    chk("rstv_outs", 32'({byte_ready, config_en, bs_out, reset_nn, done, error}), 32'd0);
    chk("rstv_crc", 32'(crc_out), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rstv_idle", 32'(busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] b0 = 8'($urandom);
      logic [7:0] b1 = 8'($urandom);
      logic vfy = 1'($urandom);
      int gap = int'($urandom_range(0, 5));
      int fidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CL - 1)) : -1;
      run_load(b0, b1, vfy, gap, fidx, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/retospect_config_loader.md
RETOSPECT_CONFIG_LOADER -- requirements
Module: retospect_config_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 1568: total configuration-chain length in bits.
REQ-002 Parameter CNT_W, default 11: bit-counter width; SHALL satisfy 2^CNT_W > CHAIN_LEN.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 verify_en  input  1  latched with start; 1 = run readback pass after load.
REQ-007 abort  input  1  cancel any operation in progress.
REQ-008 byte_in  input  8  configuration byte, shifted LSB first.
REQ-009 byte_valid  input  1  byte_in valid.
REQ-010 byte_ready  output  1  loader accepts byte_in this cycle when byte_valid=1.
REQ-011 config_en  output  1  chain shift enable.
REQ-012 bs_out  output  1  serial bit driven into the chain input.
REQ-013 bs_ret  input  1  serial bit returned from the chain output.
REQ-014 reset_nn  output  1  one-cycle network-state reset pulse after a good load.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 error  output  1  sticky; set on CRC mismatch or abort, cleared by the next accepted start.
REQ-018 crc_out  output  8  CRC of the last completed load pass.

Function
REQ-019 States SHALL be IDLE, LOAD, VERIFY, ARM and FINISH.
REQ-020 IDLE: on start=1, latch verify_en, clear error, CRC, bit counter and byte buffer, and enter LOAD next cycle; start in any other state SHALL be ignored.
REQ-021 Byte buffer: 8-bit shifter plus 4-bit fill count; byte_ready = LOAD and (fill=0, or fill=1 with a shift this cycle) and (bits requested < CHAIN_LEN).
REQ-022 A byte is accepted on byte_valid and byte_ready; the buffer SHALL load byte_in with fill=8, giving gap-free shifting at one bit per cycle under continuous valid.
REQ-023 LOAD: when fill>0, config_en=1, bs_out=buffer[0], buffer shifts right, fill decrements, and the bit counter increments; when fill=0, config_en=0 and the chain holds.
REQ-024 Each LOAD bit SHALL update the CRC-8 (poly 0x07, init 0x00): fb=crc[7]^bit; crc={crc[6:0],0}^(fb?0x07:0x00).
REQ-025 When the bit counter reaches CHAIN_LEN, the state SHALL leave LOAD next cycle; buffered bits beyond CHAIN_LEN are discarded; crc_out SHALL latch the load CRC.
REQ-026 From LOAD exit: enter VERIFY if verify_en was latched, otherwise enter ARM.
REQ-027 VERIFY: for exactly CHAIN_LEN cycles, config_en=1 and bs_out=bs_ret (recirculation, which preserves chain contents); a second CRC-8 SHALL accumulate bs_ret.
REQ-028 At VERIFY end: if the readback CRC equals the load CRC, enter ARM; otherwise set error=1 and enter FINISH, with no reset_nn pulse.
REQ-029 ARM: reset_nn=1 for exactly one cycle with config_en=0, then enter FINISH.
REQ-030 FINISH: done=1 for one cycle, then enter IDLE.
REQ-031 abort=1 in LOAD, VERIFY or ARM: next cycle state=IDLE, config_en=0, error=1, no done, no reset_nn; abort in IDLE has no effect.
REQ-032 config_en and reset_nn SHALL never be high in the same cycle; bs_out=0 whenever config_en=0.

Reset
REQ-033 reset=1 SHALL force, on the next edge: state IDLE, byte_ready 0, config_en 0, bs_out 0, reset_nn 0, busy 0, done 0, error 0, crc_out 0x00, and counters and buffer cleared.
REQ-034 reset SHALL take priority over abort, start and all handshakes, including mid-LOAD and mid-VERIFY.

Verification (CHAIN_LEN=12, 12-bit shift-register chain model)
REQ-035 Verify scenario: start, verify_en=0, bytes 0xA5 then 0x0F back-to-back -> bs_out 1,0,1,0,0,1,0,1,1,1,1,1 on 12 consecutive config_en cycles; reset_nn pulse; done pulse; error=0.
REQ-036 Verify scenario: same bytes with verify_en=1 -> 12 recirculation cycles; chain content unchanged; readback CRC equals crc_out; reset_nn then done; error=0.
REQ-037 Verify scenario: verify_en=1 with the model inverting one returned bit -> error=1, reset_nn never asserted, done pulses once.
REQ-038 Verify scenario: byte_valid with 5-cycle gaps between bytes -> config_en low during the gaps; exactly 12 config_en cycles in LOAD; same bit order as REQ-035.
REQ-039 Verify scenario: abort after 6 bits -> IDLE next cycle, error=1, no done, no reset_nn; a subsequent start clears error and completes normally.
REQ-040 Verify scenario: reset pulse during VERIFY -> all outputs at their REQ-033 values next cycle; start during busy is ignored.
